// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and width/saturation helpers for the perceptron MAC core
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_DECIDE = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Accumulator wide enough for bias plus N_INPUTS full-scale weights without overflow.
    function automatic int acc_width(input int n_inputs, input int w_width);
        return w_width + $clog2(n_inputs + 1);
    endfunction

    function automatic int sat_max(input int w_width);
        return (1 << (w_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w_width);
        return -(1 << (w_width - 1));
    endfunction

endpackage

// File: rtl/perceptron_mac_core_if.sv
// rtl/perceptron_mac_core_if.sv - config, start/result handshake bundle for the perceptron MAC core
interface perceptron_mac_core_if
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = 8
);
    localparam int IDX_W = $clog2(N_INPUTS + 1);
    localparam int ACC_W = acc_width(N_INPUTS, W_WIDTH);

    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_addr;
    logic signed [W_WIDTH-1:0] cfg_wdata;
    logic                      start;
    logic [N_INPUTS-1:0]       x_in;
    logic                      learn;
    logic                      target;
    logic                      busy;
    logic                      done;
    logic                      fire;
    logic signed [ACC_W-1:0]   sum;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, x_in, learn, target,
        input  busy, done, fire, sum
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, x_in, learn, target,
        output busy, done, fire, sum
    );

endinterface

// File: rtl/perceptron_sat_add.sv
// rtl/perceptron_sat_add.sv - signed saturating add of +/-LR to one weight
module perceptron_sat_add
    import perceptron_pkg::*;
#(
    parameter int W_WIDTH = 8,
    parameter int LR      = 1
) (
    input  logic signed [W_WIDTH-1:0] a,
    input  logic                      up,
    output logic signed [W_WIDTH-1:0] y
);
    localparam logic signed [W_WIDTH:0]   STEP  = (W_WIDTH + 1)'(LR);
    localparam logic signed [W_WIDTH-1:0] MAX_V = W_WIDTH'(sat_max(W_WIDTH));
    localparam logic signed [W_WIDTH-1:0] MIN_V = W_WIDTH'(sat_min(W_WIDTH));

    logic signed [W_WIDTH:0] ext;

    // One guard bit: disagreement between the top two bits means the result left the range.
    always_comb begin
        ext = up ? ({a[W_WIDTH-1], a} + STEP) : ({a[W_WIDTH-1], a} - STEP);
        if (ext[W_WIDTH] != ext[W_WIDTH-1]) begin
            y = ext[W_WIDTH] ? MIN_V : MAX_V;
        end else begin
            y = ext[W_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/perceptron_mac_core.sv
// rtl/perceptron_mac_core.sv - serial-MAC single-neuron perceptron with optional perceptron-rule learning
module perceptron_mac_core
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = 8,
    parameter int LR       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    perceptron_mac_core_if.slave bus
);
    localparam int IDX_W = $clog2(N_INPUTS + 1);
    localparam int ACC_W = acc_width(N_INPUTS, W_WIDTH);
    localparam logic [IDX_W-1:0] LAST_X = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0] BIAS_A = IDX_W'(N_INPUTS);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          index_q;
    logic [N_INPUTS-1:0]       x_q;
    logic                      learn_q, target_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [W_WIDTH-1:0] w_q [0:N_INPUTS];
    logic                      busy_q, done_q, fire_q;
    logic signed [ACC_W-1:0]   sum_q;

    logic                      wr_en;
    logic [IDX_W-1:0]          wr_addr;
    logic signed [W_WIDTH-1:0] wr_data;
    logic                      accept, finish;

    // Bias sits at index N_INPUTS and behaves as an always-set input.
    logic [N_INPUTS:0]         x_ext;
    logic                      x_cur;
    logic signed [W_WIDTH-1:0] w_cur;
    logic signed [ACC_W-1:0]   w_cur_ext;
    logic signed [W_WIDTH-1:0] upd_w;
    logic                      acc_ge0;
    logic                      cfg_hit;
    logic signed [W_WIDTH-1:0] bias_now;

    assign x_ext     = {1'b1, x_q};
    assign x_cur     = x_ext[index_q];
    assign w_cur     = w_q[index_q];
    assign w_cur_ext = ACC_W'(w_cur);
    assign acc_ge0   = ~acc_q[ACC_W-1];
    assign cfg_hit   = bus.cfg_we && (bus.cfg_addr <= BIAS_A);
    // A bias write in the start cycle must already be seen by the accumulator seed.
    assign bias_now  = (cfg_hit && (bus.cfg_addr == BIAS_A)) ? bus.cfg_wdata : w_q[N_INPUTS];

    perceptron_sat_add #(
        .W_WIDTH (W_WIDTH),
        .LR      (LR)
    ) u_sat_add (
        .a  (w_cur),
        .up (target_q),
        .y  (upd_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = bus.cfg_addr;
        wr_data = bus.cfg_wdata;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_en = cfg_hit;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (index_q == LAST_X) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (learn_q && (acc_ge0 != target_q)) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            ST_UPDATE: begin
                wr_en   = x_cur;
                wr_addr = index_q;
                wr_data = upd_w;
                if (index_q == BIAS_A) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= N_INPUTS; i++) w_q[i] <= '0;
        end else if (wr_en) begin
            w_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q  <= '0;
            x_q      <= '0;
            learn_q  <= 1'b0;
            target_q <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fire_q   <= 1'b0;
            sum_q    <= '0;
        end else begin
            done_q <= finish;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        x_q      <= bus.x_in;
                        learn_q  <= bus.learn;
                        target_q <= bus.target;
                        acc_q    <= ACC_W'(bias_now);
                        index_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_ACC: begin
                    acc_q   <= acc_q + (x_cur ? w_cur_ext : '0);
                    index_q <= index_q + 1'b1;
                end
                ST_DECIDE: begin
                    sum_q   <= acc_q;
                    fire_q  <= acc_ge0;
                    index_q <= '0;
                end
                ST_UPDATE: begin
                    index_q <= index_q + 1'b1;
                end
                default: ;
            endcase
            if (finish) begin
                busy_q  <= 1'b0;
                index_q <= '0;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.fire = fire_q;
    assign bus.sum  = sum_q;

endmodule

// File: tb/tb_perceptron_mac_core.sv
// tb/tb_perceptron_mac_core.sv - scoreboard bench for perceptron_mac_core (N_INPUTS=4, W_WIDTH=8, LR=1)
module tb_perceptron_mac_core;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    perceptron_mac_core_if #(.N_INPUTS(N), .W_WIDTH(W)) bus ();

    perceptron_mac_core #(.N_INPUTS(N), .W_WIDTH(W), .LR(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int sum;
        bit fire;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   mw[0:N];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   got;
    int   bias_seen;
    bit   saw_done;

    task automatic check_eq(input string tag, input longint obs, input longint exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int msat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic wr_cfg(input int addr, input int data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(addr);
        bus.cfg_wdata = 8'(data);
        mw[addr]      = data;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    // co_we: bias write in the same cycle as start; inject: cfg write + start pulse while busy
    task automatic run(input logic [N-1:0] x, input bit lrn, input bit tgt, input bit inject,
                       input bit co_we, input int co_data, output int sum_out);
        exp_t e;
        exp_t o;
        int   s;
        int   lat;
        int   bcnt;
        bit   seen;
        if (co_we) mw[N] = co_data;
        s = mw[N];
        for (int i = 0; i < N; i++) if (x[i]) s += mw[i];
        e.sum  = s;
        e.fire = (s >= 0);
        e.lat  = (lrn && (e.fire != tgt)) ? 2 * N + 2 : N + 1;
        if (lrn && (e.fire != tgt))
            for (int i = 0; i <= N; i++)
                if (i == N || x[i]) mw[i] = msat(mw[i] + (tgt ? 1 : -1));
        sb.push_back(e);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.x_in   = x;
        bus.learn  = lrn;
        bus.target = tgt;
        if (co_we) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = 3'(N);
            bus.cfg_wdata = 8'(co_data);
        end
        lat  = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = c - 1;
            end
            if (c == 1) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (inject && c == 2) begin
                bus.start     = 1'b1;
                bus.x_in      = '1;
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 3'(N);
                bus.cfg_wdata = 8'sd50;
            end
            if (inject && c == 3) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
        o = sb.pop_front();
        check_eq("sum", bus.sum, o.sum);
        check_eq("fire", bus.fire, o.fire);
        check_eq("latency", lat, o.lat);
        check_eq("busy_cycles", bcnt, o.lat);
        sum_out = bus.sum;
        @(negedge clk);
        check_eq("done_pulse", bus.done, 0);
        check_eq("idle_after", bus.busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.start     = 1'b0;
        bus.x_in      = '0;
        bus.learn     = 1'b0;
        bus.target    = 1'b0;
        for (int i = 0; i <= N; i++) mw[i] = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_fire", bus.fire, 0);
        check_eq("rst_sum", bus.sum, 0);
        rst = 1'b0;

        wr_cfg(0, 3);
        wr_cfg(1, -2);
        wr_cfg(2, 5);
        wr_cfg(3, 1);
        wr_cfg(4, -4);
        run(4'b0101, 0, 0, 0, 0, 0, got);
        check_eq("vec1_sum", got, 4);
        run(4'b0010, 0, 0, 0, 0, 0, got);
        check_eq("vec2_sum", got, -6);

        run(4'b0010, 1, 1, 0, 0, 0, got);
        check_eq("learn_sum", got, -6);
        run(4'b0000, 0, 0, 0, 0, 0, bias_seen);
        check_eq("rb_bias", bias_seen, -3);
        run(4'b0010, 0, 0, 0, 0, 0, got);
        check_eq("rb_w1", got - bias_seen, -1);

        wr_cfg(0, 127);
        wr_cfg(4, 127);
        run(4'b0001, 1, 0, 0, 0, 0, got);
        run(4'b0000, 0, 0, 0, 0, 0, bias_seen);
        check_eq("dec_bias", bias_seen, 126);
        run(4'b0001, 0, 0, 0, 0, 0, got);
        check_eq("dec_w0", got - bias_seen, 126);

        wr_cfg(0, 127);
        wr_cfg(4, -128);
        run(4'b0001, 1, 1, 0, 0, 0, got);
        run(4'b0000, 0, 0, 0, 0, 0, bias_seen);
        check_eq("sat_bias", bias_seen, -127);
        run(4'b0001, 0, 0, 0, 0, 0, got);
        check_eq("sat_w0", got - bias_seen, 127);

        run(4'b0001, 0, 0, 1, 0, 0, got);
        run(4'b0000, 0, 0, 0, 0, 0, got);
        check_eq("busy_write_ignored", got, -127);

        run(4'b0001, 0, 0, 0, 1, 10, got);
        check_eq("write_then_start", got, 137);

        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 4'b1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_done", bus.done, 0);
        for (int i = 0; i <= N; i++) mw[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check_eq("midrst_quiet", saw_done, 0);
        run(4'b1111, 0, 0, 0, 0, 0, got);
        check_eq("midrst_weights", got, 0);
        run(4'b0000, 0, 0, 0, 0, 0, got);
        check_eq("midrst_bias", got, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
